// File: rtl/gfau_pkg.sv
// gfau_pkg
// Shared types and helpers for the streaming GF(p) arithmetic unit.
//   op_e      : operation code carried on the 'op' port (ADD/SUB/MUL/DIV)
//   state_e   : control FSM states
//   op_onehot : maps an op code to the {div,mul,sub,add} done vector
package gfau_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [3:0] op_onehot(input op_e op);
    logic [3:0] v;
    case (op)
      OP_ADD:  v = 4'b0001;
      OP_SUB:  v = 4'b0010;
      OP_MUL:  v = 4'b0100;
      default: v = 4'b1000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gf_mod_addsub.sv
// gf_mod_addsub
// Combinational modular adder/subtractor: z = (x + y) mod p or (x - y) mod p.
// Operands are assumed already reduced (< p), so one conditional correction
// is enough. Sums are formed at WIDTH+1 bits so x + y never overflows.
//   x, y : operands (< p)
//   p    : modulus
//   sub  : 1 selects subtraction, 0 addition
//   z    : reduced result
module gf_mod_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  input  logic             sub,
  output logic [WIDTH-1:0] z
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    if (sub) begin
      // Wrap a negative difference by adding p first; the WIDTH+1 bit
      // intermediate keeps x + p from overflowing.
      if (x < y) z = WIDTH'({1'b0, x} + {1'b0, p} - {1'b0, y});
      else       z = x - y;
    end else begin
      if (sum >= {1'b0, p}) z = WIDTH'(sum - {1'b0, p});
      else                  z = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/gfau_stream.sv
// gfau_stream
// Streaming GF(p) arithmetic unit: modular ADD, SUB, MUL and DIV with a
// valid/ready request port, back-pressured result port, divide-by-zero flag
// and synchronous abort.
//   i_clk, i_rst          : clock, asynchronous active-low reset
//   i_clear               : synchronous abort to IDLE, drops pending result
//   in_valid / in_ready   : request handshake (ready only when idle)
//   in_0, in_1, prime, op : operands, modulus and op code, latched at accept
//   out_valid / out_ready : result handshake, result held until accepted
//   result, out_done, err : result value, one-hot op copy, DIV-by-zero flag
module gfau_stream
  import gfau_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] prime,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       out_done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       done_q, done_d;
  logic             err_q, err_d;

  op_e              in_op;
  logic [WIDTH-1:0] as0_x, as0_y, as0_p, as0_z;
  logic             as0_sub;
  logic [WIDTH-1:0] as1_z;
  logic [WIDTH-1:0] mul_step;

  assign in_op     = op_e'(op);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign out_done  = done_q;
  assign err       = err_q;

  // Exact halving modulo p: odd values get p added first so the division by
  // two is exact; the carry out of x + p becomes the top bit of the result.
  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] p);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, p};
    if (x[0]) return WIDTH'(s >> 1);
    else      return x >> 1;
  endfunction

  // Shared modular adder: ADD/SUB straight off the input port while idle,
  // the doubling step during MUL, and the x1/x2 difference during DIV.
  always_comb begin
    as0_x   = x1_q;
    as0_y   = x1_q;
    as0_sub = 1'b0;
    as0_p   = p_q;
    case (state_q)
      S_IDLE: begin
        as0_x   = in_0;
        as0_y   = in_1;
        as0_sub = (in_op == OP_SUB);
        as0_p   = prime;
      end
      S_DIV: begin
        as0_sub = 1'b1;
        if (u_q >= v_q) begin
          as0_x = x1_q;
          as0_y = x2_q;
        end else begin
          as0_x = x2_q;
          as0_y = x1_q;
        end
      end
      default: ;
    endcase
  end

  gf_mod_addsub #(.WIDTH(WIDTH)) u_addsub0 (
    .x   (as0_x),
    .y   (as0_y),
    .p   (as0_p),
    .sub (as0_sub),
    .z   (as0_z)
  );

  // Second adder folds in A after the doubling when the current bit of B is set.
  gf_mod_addsub #(.WIDTH(WIDTH)) u_addsub1 (
    .x   (as0_z),
    .y   (a_q),
    .p   (p_q),
    .sub (1'b0),
    .z   (as1_z)
  );

  assign mul_step = b_q[cnt_q] ? as1_z : as0_z;

  // Next-state and datapath update. MUL keeps its accumulator in x1 so the
  // DIV registers double as MUL storage.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          a_d  = in_0;
          b_d  = in_1;
          p_d  = prime;
          case (in_op)
            OP_ADD, OP_SUB: begin
              result_d = as0_z;
              err_d    = 1'b0;
              done_d   = op_onehot(in_op);
              state_d  = S_DONE;
            end
            OP_MUL: begin
              x1_d    = '0;
              cnt_d   = CW'(WIDTH - 1);
              state_d = S_MUL;
            end
            default: begin
              if (in_1 == '0) begin
                result_d = '0;
                err_d    = 1'b1;
                done_d   = op_onehot(OP_DIV);
                state_d  = S_DONE;
              end else begin
                u_d     = in_1;
                v_d     = prime;
                x1_d    = in_0;
                x2_d    = '0;
                state_d = S_DIV;
              end
            end
          endcase
        end
      end

      S_MUL: begin
        x1_d = mul_step;
        if (cnt_q == '0) begin
          result_d = mul_step;
          err_d    = 1'b0;
          done_d   = op_onehot(op_q);
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DIV: begin
        // Invariants: x1*B == A*u and x2*B == A*v (mod p).
        if (u_q == WIDTH'(1) || v_q == WIDTH'(1)) begin
          result_d = (u_q == WIDTH'(1)) ? x1_q : x2_q;
          err_d    = 1'b0;
          done_d   = op_onehot(op_q);
          state_d  = S_DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = halve(x1_q, p_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = halve(x2_q, p_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = as0_z;
        end else begin
          v_d  = v_q - u_q;
          x2_d = as0_z;
        end
      end

      default: begin
        if (out_ready) begin
          done_d  = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase

    if (i_clear) begin
      done_d  = '0;
      err_d   = 1'b0;
      state_d = S_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_gfau_stream.sv
// tb_gfau_stream
// Directed bench for gfau_stream: a WIDTH=32 instance covers the main
// behaviour, a WIDTH=8 instance covers the narrow-width MUL case.
module tb_gfau_stream;
  import gfau_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_0, in_1, prime;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_done;
  logic        err;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, err8;
  logic [7:0]  in_08, in_18, prime8, result8;
  logic [1:0]  op8;
  logic [3:0]  out_done8;

  int errors = 0;
  int checks = 0;

  gfau_stream #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_0(in_0), .in_1(in_1), .prime(prime), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_done(out_done), .err(err)
  );

  gfau_stream #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst_n), .i_clear(clear),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_0(in_08), .in_1(in_18), .prime(prime8), .op(op8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .out_done(out_done8), .err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request, wait for the accept edge, then count edges
  // (accept edge = 1) until out_valid is seen at a falling edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] p,
                               output int lat);
    @(negedge clk);
    checkOutput("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_0 = a; in_1 = b; prime = p; op = o; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) checkOutput("timeout", 32'd1, 32'd0);
  endtask

  // Hand the pending result over and confirm the unit is ready again.
  task automatic takeResult;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("ready_after_handoff", {31'd0, in_ready}, 32'd1);
    checkOutput("valid_after_handoff", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic runAndCheck(input string tag, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] p, input logic [31:0] exp_res,
                             input logic [3:0] exp_done, input logic exp_err,
                             input int exp_lat);
    int lat;
    applyStimulus(o, a, b, p, lat);
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_done"}, {28'd0, out_done}, {28'd0, exp_done});
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    if (exp_lat > 0) checkOutput({tag, "_lat"}, lat, exp_lat);
    else checkOutput({tag, "_lat_bound"}, {31'd0, lat <= 129}, 32'd1);
    takeResult();
  endtask

  initial begin
    int  lat;
    logic seen;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_0 = '0; in_1 = '0; prime = '0; op = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; in_08 = '0; in_18 = '0;
    prime8 = '0; op8 = '0;
    #12;
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_done", {28'd0, out_done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, p = 23.
    runAndCheck("add",      2'd0, 32'h14, 32'h05, 32'h17, 32'h02, 4'b0001, 1'b0, 1);
    runAndCheck("add_eq_p", 2'd0, 32'h10, 32'h07, 32'h17, 32'h00, 4'b0001, 1'b0, 1);
    runAndCheck("add_max",  2'd0, 32'h16, 32'h16, 32'h17, 32'h15, 4'b0001, 1'b0, 1);
    runAndCheck("sub",      2'd1, 32'h03, 32'h07, 32'h17, 32'h13, 4'b0010, 1'b0, 1);
    runAndCheck("sub_zero", 2'd1, 32'h05, 32'h05, 32'h17, 32'h00, 4'b0010, 1'b0, 1);
    runAndCheck("mul",      2'd2, 32'h07, 32'h09, 32'h17, 32'h11, 4'b0100, 1'b0, 33);
    runAndCheck("mul_max",  2'd2, 32'h16, 32'h16, 32'h17, 32'h01, 4'b0100, 1'b0, 33);
    runAndCheck("div",      2'd3, 32'h01, 32'h05, 32'h17, 32'h0E, 4'b1000, 1'b0, 7);
    runAndCheck("div_7_3",  2'd3, 32'h07, 32'h03, 32'h17, 32'h0A, 4'b1000, 1'b0, 0);
    runAndCheck("div_by1",  2'd3, 32'h09, 32'h01, 32'h17, 32'h09, 4'b1000, 1'b0, 0);
    runAndCheck("div_zero", 2'd3, 32'h03, 32'h00, 32'h17, 32'h00, 4'b1000, 1'b1, 1);

    // Narrow instance: 250 * 250 mod 251 = 1 after WIDTH+1 = 9 edges.
    @(negedge clk);
    in_08 = 8'hFA; in_18 = 8'hFA; prime8 = 8'hFB; op8 = 2'd2; in_valid8 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("w8_mul_result", {24'd0, result8}, 32'h01);
    checkOutput("w8_mul_lat", lat, 9);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    checkOutput("w8_ready_after", {31'd0, in_ready8}, 32'd1);

    // Back-pressure: result held, new request ignored while DONE.
    applyStimulus(2'd2, 32'h07, 32'h09, 32'h17, lat);
    in_0 = 32'h01; in_1 = 32'h01; op = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_result", result, 32'h11);
      checkOutput("bp_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_done", {28'd0, out_done}, 32'b0100);
    end
    in_valid = 1'b0;
    takeResult();

    // Abort: clear after 10 MUL edges; no result may appear.
    @(negedge clk);
    in_0 = 32'h07; in_1 = 32'h09; prime = 32'h17; op = 2'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    checkOutput("abort_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    checkOutput("abort_no_valid", {31'd0, seen}, 32'd0);
    runAndCheck("post_abort_add", 2'd0, 32'h14, 32'h05, 32'h17, 32'h02, 4'b0001, 1'b0, 1);

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    in_0 = 32'h01; in_1 = 32'h05; prime = 32'h17; op = 2'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_result", result, 32'd0);
    checkOutput("mid_rst_done", {28'd0, out_done}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runAndCheck("post_rst_sub", 2'd1, 32'h00, 32'h16, 32'h17, 32'h01, 4'b0010, 1'b0, 1);
    runAndCheck("post_rst_div", 2'd3, 32'h01, 32'h05, 32'h17, 32'h0E, 4'b1000, 1'b0, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
